nv_ram_rwsp_fifo_ctrl: RTL

- Control half of a 1R1W synchronous FIFO. Drives the write and read ports of an external nv_ram_rwsp_* macro, which has a registered read address (re) and a registered output (ore).
- Converts a valid/ready push stream and a valid/ready pop stream into RAM port activity.
- Manages the 2-stage read pipeline (address register, then output register) with full back-pressure.
- Sits between a producer/consumer pair and the RAM instance inside NVDLA sub-unit buffers.

---
 rtl/nv_ram_rwsp_fifo_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// Control half of a 1R1W FIFO around an nv_ram_rwsp macro (registered read address + output register).
// Optional occupancy/high-watermark ports are enabled with NV_RAM_RWSP_FIFO_CTRL_OCC_EN.
`timescale 1ns/1ps
module nv_ram_rwsp_fifo_ctrl #(
  parameter int AW = 7,
  parameter int DW = 6
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
`ifdef NV_RAM_RWSP_FIFO_CTRL_OCC_EN
  output logic [AW+1:0] occ,
  output logic [AW+1:0] occ_max,
`endif
  output logic [31:0]   ram_pwrbus_pd
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   iss_q, iss_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;
  logic          push;
  logic          s1_free;
  logic          s2_free;

  // A slot stays owned until ore captures it, so cnt (not iss) gates the writer.
  always_comb begin
    wr_prdy = (cnt_q < DEPTH_C);
    push    = wr_pvld & wr_prdy;
    ram_we  = push;
    ram_wa  = wr_ptr_q;
    ram_di  = wr_pd;

    s2_free = !s2_vld_q | rd_prdy;
    ram_ore = s1_vld_q & s2_free;
    s1_free = !s1_vld_q | ram_ore;
    ram_re  = (iss_q != '0) & s1_free;
    ram_ra  = rd_ptr_q;

    rd_pvld       = s2_vld_q;
    rd_pd         = ram_dout;
    ram_pwrbus_pd = pwrbus_ram_pd;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(ram_re);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(ram_ore);
    iss_d    = iss_q + (AW+1)'(push) - (AW+1)'(ram_re);
    s1_vld_d = ram_re | (s1_vld_q & !ram_ore);
    s2_vld_d = ram_ore | (s2_vld_q & !rd_prdy);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      iss_q    <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      iss_q    <= iss_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

`ifdef NV_RAM_RWSP_FIFO_CTRL_OCC_EN
  logic [AW+1:0] occ_max_q, occ_max_d;

  // Entries in the RAM plus the one parked in the output register.
  always_comb begin
    occ       = (AW+2)'(cnt_q) + (AW+2)'(s2_vld_q);
    occ_max_d = (occ > occ_max_q) ? occ : occ_max_q;
    occ_max   = occ_max_q;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      occ_max_q <= '0;
    end else begin
      occ_max_q <= occ_max_d;
    end
  end
`endif

endmodule
